// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST driver: FSM state encoding and LFSR constants.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int unsigned LFSR_WIDTH = 32;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 32'h8020_0003;

    // One Galois step: shift right, fold the mask in when the bit shifted out was 1.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
import adder_bist_pkg::*;

module bist_lfsr #(
    parameter logic [LFSR_WIDTH-1:0] RESET_SEED = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] state
);

    // Load takes priority over step; otherwise the register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_advance(state);
        end
    end

endmodule

// File: rtl/adder_bist_driver.sv
// Built-in self-test driver for a combinational ripple adder: applies LFSR operands,
// waits a settle window, compares against a golden sum and reports pass/fail.
import adder_bist_pkg::*;

module adder_bist_driver #(
    parameter int unsigned            WIDTH         = 8,
    parameter int unsigned            NUM_VECTORS   = 10,
    parameter int unsigned            SETTLE_CYCLES = 1,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED     = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_c_in,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_c_out
);

    localparam logic [15:0] LAST_IDX    = (NUM_VECTORS == 0) ? 16'd0 : 16'(NUM_VECTORS - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
    localparam logic [15:0] NO_FAIL     = 16'hFFFF;

    state_t                  state;
    state_t                  state_nxt;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic                    lfsr_load;
    logic                    lfsr_step;
    logic [15:0]             vec_idx;
    logic [15:0]             settle_cnt;
    logic [WIDTH:0]          exp_sum;
    logic                    last_vec;
    logic                    mismatch;

    bist_lfsr #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign last_vec = (vec_idx == LAST_IDX);
    // Case inequality so that an undriven or X adder output is flagged in simulation.
    assign mismatch = ({dut_c_out, dut_sum} !== exp_sum);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and LFSR control strobes.
    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_nxt = (NUM_VECTORS == 0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                lfsr_step = 1'b1;
                state_nxt = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt <= 16'd1) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = last_vec ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand drive, golden sum, settle counter, error bookkeeping and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= NO_FAIL;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_c_in   <= 1'b0;
            exp_sum    <= '0;
            vec_idx    <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= NO_FAIL;
                        vec_idx    <= '0;
                    end
                end
                ST_APPLY: begin
                    dut_a      <= lfsr[WIDTH-1:0];
                    dut_b      <= lfsr[2*WIDTH-1:WIDTH];
                    dut_c_in   <= lfsr[2*WIDTH];
                    exp_sum    <= {1'b0, lfsr[WIDTH-1:0]}
                                + {1'b0, lfsr[2*WIDTH-1:WIDTH]}
                                + {{WIDTH{1'b0}}, lfsr[2*WIDTH]};
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 16'd1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (first_fail == NO_FAIL) begin
                            first_fail <= vec_idx;
                        end
                    end
                    if (!last_vec) begin
                        vec_idx <= vec_idx + 16'd1;
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 16'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_driver.sv
// Self-checking bench for adder_bist_driver with a fault-injectable behavioural adder.
module tb_adder_bist_driver;

    localparam int          NV   = 10;
    localparam int          SC   = 1;
    localparam int          LAT  = 1 + NV * (2 + SC);
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start0;
    int          fault_mode;

    logic        busy, done, pass;
    logic [15:0] err_count, first_fail;
    logic [7:0]  dut_a, dut_b, dut_sum;
    logic        dut_c_in, dut_c_out;
    logic [8:0]  adder_out;

    logic        busy0, done0, pass0;
    logic [15:0] err0, ff0;
    logic [7:0]  a0, b0, sum0;
    logic        c0, cout0;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ma[$];
    logic [7:0]  mb[$];
    logic        mc[$];
    int          m_err;
    logic [15:0] m_ff;

    always #5 clk = ~clk;

    // Adder under test: mode 0 correct, 1 sum[0] stuck-at-0, 2 carry-out tied 0.
    function automatic logic [8:0] fault_adder(input logic [7:0] a, input logic [7:0] b,
                                               input logic c, input int mode);
        logic [8:0] s;
        s = 9'(a) + 9'(b) + 9'(c);
        if (mode == 1) s[0] = 1'b0;
        else if (mode == 2) s[8] = 1'b0;
        return s;
    endfunction

    always_comb adder_out = fault_adder(dut_a, dut_b, dut_c_in, fault_mode);
    assign dut_sum   = adder_out[7:0];
    assign dut_c_out = adder_out[8];
    assign {cout0, sum0} = 9'(a0) + 9'(b0) + 9'(c0);

    adder_bist_driver #(
        .WIDTH(8), .NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail), .dut_a(dut_a), .dut_b(dut_b),
        .dut_c_in(dut_c_in), .dut_sum(dut_sum), .dut_c_out(dut_c_out)
    );

    adder_bist_driver #(
        .WIDTH(8), .NUM_VECTORS(0), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)
    ) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .dut_a(a0), .dut_b(b0),
        .dut_c_in(c0), .dut_sum(sum0), .dut_c_out(cout0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the LFSR arithmetically, record operands and expected error stats.
    task automatic build_model(input int mode);
        logic [31:0] s;
        int          truth;
        logic [8:0]  got;
        s = SEED;
        ma.delete(); mb.delete(); mc.delete();
        m_err = 0;
        m_ff  = 16'hFFFF;
        for (int k = 0; k < NV; k++) begin
            ma.push_back(s[7:0]);
            mb.push_back(s[15:8]);
            mc.push_back(s[16]);
            truth = int'(s[7:0]) + int'(s[15:8]) + int'(s[16]);
            got   = fault_adder(s[7:0], s[15:8], s[16], mode);
            if (int'(got) != truth) begin
                m_err++;
                if (m_ff == 16'hFFFF) m_ff = 16'(k);
            end
            s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        end
    endtask

    task automatic wait_run(input string tag);
        int k;
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk); #1;
            chk({tag, "_busy"}, 32'(busy), 32'(n < LAT));
            chk({tag, "_done"}, 32'(done), 32'(n == LAT));
            if ((n - 1) % (2 + SC) == 1) begin
                k = (n - 1) / (2 + SC);
                chk({tag, "_dut_a"}, 32'(dut_a), 32'(ma[k]));
                chk({tag, "_dut_b"}, 32'(dut_b), 32'(mb[k]));
                chk({tag, "_dut_c_in"}, 32'(dut_c_in), 32'(mc[k]));
            end
        end
        chk({tag, "_err_count"}, 32'(err_count), 32'(m_err));
        chk({tag, "_first_fail"}, 32'(first_fail), 32'(m_ff));
        chk({tag, "_pass"}, 32'(pass), 32'(m_err == 0));
    endtask

    task automatic do_run(input int mode, input bit hold);
        fault_mode = mode;
        build_model(mode);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        wait_run("run");
        @(posedge clk); #1;
        if (hold) begin
            chk("retrigger_busy", 32'(busy), 32'd1);
            chk("retrigger_done", 32'(done), 32'd0);
            start = 1'b0;
            wait_run("rerun");
            @(posedge clk); #1;
        end
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("pass_hold", 32'(pass), 32'(m_err == 0));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_ff"}, 32'(first_fail), 32'hFFFF);
        chk({tag, "_a"}, 32'(dut_a), 32'd0);
        chk({tag, "_b"}, 32'(dut_b), 32'd0);
        chk({tag, "_cin"}, 32'(dut_c_in), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        chk("reset_ff0", 32'(ff0), 32'hFFFF);
        @(negedge clk); rst_n = 1'b1;

        do_run(0, 1'b0);
        do_run(1, 1'b0);
        do_run(2, 1'b0);

        // Reset during the settle window of vector 4, then replay from scratch.
        fault_mode = 0;
        build_model(0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (1 + 4 * (2 + SC)) @(posedge clk);
        #1;
        chk("pre_reset_a", 32'(dut_a), 32'(ma[4]));
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrun");
        @(negedge clk); rst_n = 1'b1;
        do_run(0, 1'b0);

        do_run(0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            do_run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Zero-vector instance: done the cycle after start, operands untouched.
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        chk("zero_busy", 32'(busy0), 32'd1);
        chk("zero_done_early", 32'(done0), 32'd0);
        @(posedge clk); #1;
        chk("zero_done", 32'(done0), 32'd1);
        chk("zero_busy_end", 32'(busy0), 32'd0);
        chk("zero_pass", 32'(pass0), 32'd1);
        chk("zero_err", 32'(err0), 32'd0);
        chk("zero_ff", 32'(ff0), 32'hFFFF);
        chk("zero_ops", 32'({a0, b0, c0}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
